mem_bus_arbiter: RTL and testbench

Shares the core's single data-memory port between the instruction-fetch bus (ibus) and the load/store bus (dbus). It sits between the IF stage and the LSU on one side and the memory/bus fabric on the other, and it supplies the `lsu_rdata` consumed by the MEM stage. It allows one outstanding transaction, gives fixed priority to dbus, routes each response back to its owner, and returns a bus error if memory never responds.

---
 rtl/mem_bus_arbiter_pkg.sv | 19 +
 rtl/mem_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the ibus/dbus memory-port arbiter.
package mem_bus_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    // Owner of the single outstanding transaction
    typedef enum logic {
        OWN_IBUS = 1'b0,
        OWN_DBUS = 1'b1
    } arb_owner_e;

    // Response-timeout counter width; TIMEOUT must fit in it
    localparam int CNT_W = 8;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one data-memory port between instruction fetch (ibus) and the LSU
// (dbus). One outstanding transaction, fixed dbus priority, responses routed
// to the owner, bus error returned when memory never answers.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ibus_req,
    input  logic [ADDR_W-1:0]   ibus_addr,
    output logic                ibus_ready,
    output logic                ibus_rvalid,
    output logic [DATA_W-1:0]   ibus_rdata,
    output logic                ibus_err,

    input  logic                dbus_req,
    input  logic                dbus_write,
    input  logic [ADDR_W-1:0]   dbus_addr,
    input  logic [DATA_W-1:0]   dbus_wdata,
    input  logic [DATA_W/8-1:0] dbus_wstrb,
    output logic                dbus_ready,
    output logic                dbus_rvalid,
    output logic [DATA_W-1:0]   dbus_rdata,
    output logic                dbus_err,

    output logic                mem_req,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e       state_q, state_d;
    arb_owner_e       owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic       any_req;
    arb_owner_e sel;
    logic       accept;
    logic       timeout_hit;
    logic       rsp_fire;

    // dbus always wins; ibus only when the LSU is quiet
    always_comb begin
        any_req     = ibus_req | dbus_req;
        sel         = dbus_req ? OWN_DBUS : OWN_IBUS;
        accept      = (state_q == ARB_IDLE) && any_req && mem_ready && !rst;
        timeout_hit = (state_q == ARB_WAIT) && !mem_rvalid && (cnt_q == CNT_LAST);
        rsp_fire    = (state_q == ARB_WAIT) && (mem_rvalid || timeout_hit) && !rst;
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_IBUS;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: accept in IDLE, wait for response or timeout in WAIT
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (accept) begin
                    state_d = ARB_WAIT;
                    owner_d = sel;
                    cnt_d   = '0;
                end
            end
            ARB_WAIT: begin
                if (mem_rvalid || timeout_hit) begin
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Outputs: request forwarding from the selected bus, response routing to owner
    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = ibus_addr;
        mem_wdata   = dbus_wdata;
        mem_wstrb   = '0;
        ibus_ready  = 1'b0;
        dbus_ready  = 1'b0;
        ibus_rvalid = 1'b0;
        dbus_rvalid = 1'b0;
        ibus_err    = 1'b0;
        dbus_err    = 1'b0;
        // non-owner rdata is don't-care; pass memory data straight through
        ibus_rdata  = mem_rdata;
        dbus_rdata  = mem_rdata;

        if (sel == OWN_DBUS) begin
            mem_write = dbus_write;
            mem_addr  = dbus_addr;
            mem_wstrb = dbus_wstrb;
        end

        if (state_q == ARB_IDLE && !rst) begin
            mem_req    = any_req;
            ibus_ready = accept && (sel == OWN_IBUS);
            dbus_ready = accept && (sel == OWN_DBUS);
        end

        if (rsp_fire) begin
            if (owner_q == OWN_DBUS) begin
                dbus_rvalid = 1'b1;
                dbus_err    = timeout_hit;
                if (timeout_hit) dbus_rdata = '0;
            end else begin
                ibus_rvalid = 1'b1;
                ibus_err    = timeout_hit;
                if (timeout_hit) ibus_rdata = '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (TIMEOUT = 4).
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ibus_req;
    logic [AW-1:0] ibus_addr;
    logic          ibus_ready, ibus_rvalid, ibus_err;
    logic [DW-1:0] ibus_rdata;
    logic          dbus_req, dbus_write;
    logic [AW-1:0] dbus_addr;
    logic [DW-1:0] dbus_wdata;
    logic [3:0]    dbus_wstrb;
    logic          dbus_ready, dbus_rvalid, dbus_err;
    logic [DW-1:0] dbus_rdata;
    logic          mem_req, mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready, mem_rvalid;
    logic [DW-1:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_ready(ibus_ready),
        .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata), .ibus_err(ibus_err),
        .dbus_req(dbus_req), .dbus_write(dbus_write), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb), .dbus_ready(dbus_ready),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .dbus_err(dbus_err),
        .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // advance one clock, then settle past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // let combinational outputs settle after input changes
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        ibus_req = 0; ibus_addr = '0;
        dbus_req = 0; dbus_write = 0; dbus_addr = '0; dbus_wdata = '0; dbus_wstrb = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        tick(); tick();
        rst = 0;
        settle();
        // reset state
        chk("rst_mem_req",    mem_req, 0);
        chk("rst_ready",      {ibus_ready, dbus_ready}, 0);
        chk("rst_rvalid_err", {ibus_rvalid, dbus_rvalid, ibus_err, dbus_err}, 0);

        // dbus load, response 2 cycles after accept
        dbus_req = 1; dbus_addr = 32'h100; mem_ready = 1;
        settle();
        chk("ld_mem_req",    mem_req, 1);
        chk("ld_mem_addr",   mem_addr, 32'h100);
        chk("ld_mem_write",  mem_write, 0);
        chk("ld_dbus_ready", dbus_ready, 1);
        chk("ld_ibus_ready", ibus_ready, 0);
        tick();
        dbus_req = 0; mem_ready = 0;
        settle();
        chk("ld_wait_req",    mem_req, 0);
        chk("ld_wait_rvalid", dbus_rvalid, 0);
        tick();
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        settle();
        chk("ld_rvalid", dbus_rvalid, 1);
        chk("ld_rdata",  dbus_rdata, 32'hDEADBEEF);
        chk("ld_err",    dbus_err, 0);
        chk("ld_ibus_rv", ibus_rvalid, 0);
        tick();
        mem_rvalid = 0;

        // simultaneous: dbus store first, ibus the cycle after dbus_rvalid
        ibus_req = 1; ibus_addr = 32'h0;
        dbus_req = 1; dbus_write = 1; dbus_addr = 32'h200; dbus_wdata = 32'h12345678; dbus_wstrb = 4'hF;
        mem_ready = 1;
        settle();
        chk("sim_mem_write",  mem_write, 1);
        chk("sim_mem_addr",   mem_addr, 32'h200);
        chk("sim_mem_wdata",  mem_wdata, 32'h12345678);
        chk("sim_mem_wstrb",  mem_wstrb, 4'hF);
        chk("sim_dbus_ready", dbus_ready, 1);
        chk("sim_ibus_ready", ibus_ready, 0);
        tick();
        dbus_req = 0; dbus_write = 0;
        settle();
        chk("sim_wait_req",   mem_req, 0);
        chk("sim_wait_iready", ibus_ready, 0);
        tick();
        mem_rvalid = 1;
        settle();
        chk("sim_dbus_rvalid", dbus_rvalid, 1);
        chk("sim_rsp_iready",  ibus_ready, 0);
        tick();
        mem_rvalid = 0;
        settle();
        chk("sim_ibus_ready2", ibus_ready, 1);
        chk("sim_ibus_addr",   mem_addr, 32'h0);
        chk("sim_ibus_write",  mem_write, 0);
        chk("sim_ibus_wstrb",  mem_wstrb, 4'h0);
        tick();
        ibus_req = 0; mem_ready = 0;
        mem_rvalid = 1; mem_rdata = 32'h0000CAFE;
        settle();
        chk("sim_ibus_rvalid", ibus_rvalid, 1);
        chk("sim_ibus_rdata",  ibus_rdata, 32'h0000CAFE);
        chk("sim_dbus_rv_off", dbus_rvalid, 0);
        tick();
        mem_rvalid = 0;

        // backpressure on ibus
        ibus_req = 1; ibus_addr = 32'h40; mem_ready = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("bp_mem_req",  mem_req, 1);
            chk("bp_mem_addr", mem_addr, 32'h40);
            chk("bp_ready",    ibus_ready, 0);
            tick();
        end
        mem_ready = 1;
        settle();
        chk("bp_ready_rise", ibus_ready, 1);
        tick();
        ibus_req = 0; mem_ready = 0;
        mem_rvalid = 1; mem_rdata = 32'h11;
        settle();
        chk("bp_rvalid", ibus_rvalid, 1);
        tick();
        mem_rvalid = 0;

        // timeout: error exactly 4 cycles after accept
        dbus_req = 1; dbus_addr = 32'h300; mem_ready = 1;
        settle();
        chk("to_accept", dbus_ready, 1);
        tick();
        dbus_req = 0; mem_ready = 0;
        for (int k = 1; k < 4; k++) begin
            settle();
            chk("to_early_rvalid", dbus_rvalid, 0);
            tick();
        end
        settle();
        chk("to_rvalid", dbus_rvalid, 1);
        chk("to_err",    dbus_err, 1);
        chk("to_rdata",  dbus_rdata, 0);
        chk("to_ibus",   ibus_rvalid, 0);
        tick();
        mem_rvalid = 1; mem_rdata = 32'h55;
        settle();
        chk("to_stray", {ibus_rvalid, dbus_rvalid}, 0);
        tick();
        mem_rvalid = 0;

        // reset while waiting for a response
        dbus_req = 1; dbus_addr = 32'h500; mem_ready = 1;
        settle();
        chk("rw_accept", dbus_ready, 1);
        tick();
        dbus_req = 0; mem_ready = 0;
        rst = 1;
        settle();
        chk("rw_rst_rvalid", {ibus_rvalid, dbus_rvalid}, 0);
        tick();
        rst = 0;
        mem_rvalid = 1; mem_rdata = 32'h77;
        settle();
        chk("rw_late_rvalid", {ibus_rvalid, dbus_rvalid}, 0);
        chk("rw_outs", {mem_req, ibus_ready, dbus_ready, ibus_err, dbus_err}, 0);
        tick();
        mem_rvalid = 0;
        ibus_req = 1; ibus_addr = 32'h80; mem_ready = 1;
        settle();
        chk("rw_next_ready", ibus_ready, 1);
        tick();
        ibus_req = 0; mem_ready = 0;
        mem_rvalid = 1; mem_rdata = 32'h88;
        settle();
        chk("rw_next_rvalid", ibus_rvalid, 1);
        chk("rw_next_rdata",  ibus_rdata, 32'h88);
        tick();
        mem_rvalid = 0;

        // store with single byte strobe, write ack
        dbus_req = 1; dbus_write = 1; dbus_addr = 32'h404; dbus_wdata = 32'h0000AB00; dbus_wstrb = 4'h2;
        mem_ready = 1;
        settle();
        chk("wa_wstrb", mem_wstrb, 4'h2);
        chk("wa_write", mem_write, 1);
        chk("wa_ready", dbus_ready, 1);
        tick();
        dbus_req = 0; dbus_write = 0; mem_ready = 0;
        mem_rvalid = 1; mem_rdata = 32'h0;
        settle();
        chk("wa_rvalid", dbus_rvalid, 1);
        chk("wa_err",    dbus_err, 0);
        tick();
        mem_rvalid = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
